udma_cpi_tx: RTL and testbench
==============================

Name: udma_cpi_tx

Overview:
- CPI (camera parallel interface) transmitter and sensor emulator.
- Pulls pixel bytes from a uDMA TX stream (valid/ready) and drives pclk, hsync, vsync and data with programmable frame geometry and blanking.
- Sits at the opposite end of the CPI link from the camera receiver. Used for loopback verification of the camera path and to drive external CPI sinks.
- Single clock domain; pclk is derived from clk_i by a divider and is driven as a data signal.

Parameters:
- DATA_WIDTH, 8, pixel bus width.
- CNT_WIDTH, 16, width of geometry and blanking counters.

Ports:
- clk_i  in  1  system clock
- rstn_i  in  1  asynchronous active-low reset
- cfg_en_i  in  1  enable frame generation (level)
- cfg_clkdiv_i  in  8  pclk half-period = cfg_clkdiv_i+1 clk cycles
- cfg_width_i  in  CNT_WIDTH  pixels per line minus 1
- cfg_height_i  in  CNT_WIDTH  lines per frame minus 1
- cfg_hblank_i  in  CNT_WIDTH  hsync-low pclk periods after each line, minus 1
- cfg_vblank_i  in  CNT_WIDTH  vsync-high pclk periods before each frame, minus 1
- tx_data_i  in  DATA_WIDTH  pixel from uDMA TX channel
- tx_valid_i  in  1  pixel valid
- tx_ready_o  out  1  pixel consumed this cycle
- cpi_pclk_o  out  1  CPI pixel clock
- cpi_hsync_o  out  1  line valid, active high
- cpi_vsync_o  out  1  frame blank, active high
- cpi_data_o  out  DATA_WIDTH  pixel data
- busy_o  out  1  FSM not IDLE
- eof_evt_o  out  1  one-cycle pulse at end of frame
- underrun_evt_o  out  1  one-cycle pulse when a pixel slot finds tx_valid_i low

Behaviour:
- Reset: all outputs 0; FSM in IDLE; pclk low; all counters 0.

Clock generation:
- div_cnt counts 0..clkdiv; at clkdiv, pclk toggles and div_cnt returns to 0.
- fall = (div_cnt==clkdiv) && pclk==1.
- hsync, vsync and data change only on fall edges or on IDLE->VBLANK entry. They are therefore stable across the pclk rising edge, where the receiver samples.
- In IDLE: pclk held low, div_cnt held at 0.

Configuration:
- All cfg_* except cfg_en_i are latched into shadow registers on IDLE->VBLANK entry and on each frame restart.
- Changes mid-frame take effect at the next frame.

FSM states: IDLE, VBLANK, LINE, HBLANK.
- IDLE -> VBLANK: on first clk edge with cfg_en_i=1. vsync<=1 that edge; pclk starts low.
- VBLANK: count falls. At fall number vblank+1: vsync<=0, hsync<=1, first pixel presented, enter LINE.
- LINE: each fall presents one pixel.
  - tx_ready_o = fall && (slot is a pixel), combinational.
  - Pixel fires when tx_valid_i=1: data<=tx_data_i.
  - If tx_valid_i=0: data<=0, underrun_evt_o pulses, timing is NOT stalled.
  - After width+1 pixels, next fall: hsync<=0, data<=0, enter HBLANK.
- HBLANK: at fall number hblank+1:
  - If lines remain: hsync<=1 and the next pixel is presented (as in LINE), enter LINE.
  - Else: eof_evt_o pulses. If cfg_en_i=1, vsync<=1 and shadow config is reloaded, enter VBLANK. If cfg_en_i=0, enter IDLE.
- cfg_en_i deassert mid-frame: the current frame completes, then IDLE. Never truncated.
- Boundary cases:
  - cfg_width_i=0 gives 1-pixel lines; cfg_height_i=0 gives 1-line frames.
  - Max counts of 2^CNT_WIDTH must not wrap early; compare with ==, not overflow.
- tx_ready_o is never asserted outside a pixel slot. Exactly width+1 ready pulses per line.
- Reset mid-operation: immediate return to reset values; no eof_evt_o.
- busy_o = (state != IDLE), registered.

Decomposition:
- cpi_pkg:
  - cpi_tx_state_e enum: IDLE, VBLANK, LINE, HBLANK.
  - cpi_tx_cfg_t struct: clkdiv, width, height, hblank, vblank (shadow register type).
- Sub-module cpi_tx_clkgen:
  - Inputs: clkdiv, run.
  - Outputs: pclk and fall strobe.
  - Reset to pclk=0.
- Top module: FSM, counters, shadow config, handshake.

Test Plan:
- clkdiv=0, width=3, height=1, hblank=1, vblank=0, stream 0x10..0x17 always valid -> pclk period 2 clk. vsync high 1 period. Two lines of 4 pixels (0x10-13, 0x14-17) with hsync high 4 periods and low 2 periods. One eof_evt. 8 ready pulses; a receiver model captures identical bytes.
- Same config, tx_valid_i low for the 3rd pixel slot only -> cpi_data_o=0 in that slot, one underrun_evt, line length unchanged, stream resumes with the next byte.
- clkdiv=2 -> pclk high 3 and low 3 clk cycles. Data and hsync transitions coincide only with pclk falling edges.
- cfg_en_i dropped during line 0 of a 2-line frame -> both lines complete, eof_evt pulses, then IDLE with pclk low and busy_o=0.
- cfg_width_i changed 3->7 mid-frame with cfg_en_i held -> current frame keeps 4-pixel lines; next frame uses 8-pixel lines.
- rstn_i asserted mid-LINE -> all outputs 0 immediately, no eof_evt. After release with cfg_en_i=1, a fresh frame starts with vsync.

Source files
------------

// File: rtl/udma_cpi_tx_pkg.sv
// Shared types for the CPI transmitter: FSM encoding and shadow config record.
package udma_cpi_tx_pkg;

    localparam int unsigned CPI_CNT_WIDTH = 16;
    localparam int unsigned CPI_DIV_WIDTH = 8;

    // Legacy state encodings, kept as named constants for external tooling.
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_VBLANK = 2'd1;
    localparam logic [1:0] ST_LINE   = 2'd2;
    localparam logic [1:0] ST_HBLANK = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        VBLANK = ST_VBLANK,
        LINE   = ST_LINE,
        HBLANK = ST_HBLANK
    } cpi_tx_state_e;

    // Frame geometry captured at frame start; fields are "count minus 1".
    typedef struct packed {
        logic [CPI_DIV_WIDTH-1:0] clkdiv;
        logic [CPI_CNT_WIDTH-1:0] width;
        logic [CPI_CNT_WIDTH-1:0] height;
        logic [CPI_CNT_WIDTH-1:0] hblank;
        logic [CPI_CNT_WIDTH-1:0] vblank;
    } cpi_tx_cfg_t;

endpackage

// File: rtl/udma_cpi_tx_clkgen.sv
// Pixel clock divider: pclk half-period is clkdiv+1 clk cycles, held low when idle.
module cpi_tx_clkgen
    import udma_cpi_tx_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [CPI_DIV_WIDTH-1:0] clkdiv,
    input  logic                     run,
    output logic                     pclk,
    output logic                     fall
);

    logic [CPI_DIV_WIDTH-1:0] div_cnt;
    logic                     terminal;

    assign terminal = (div_cnt == clkdiv);
    // Strobe in the cycle whose closing edge drives pclk from high to low.
    assign fall     = run && terminal && pclk;

    // Half-period counter and pclk toggle; stopped and parked low when not running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            pclk    <= 1'b0;
        end else if (!run) begin
            div_cnt <= '0;
            pclk    <= 1'b0;
        end else if (terminal) begin
            div_cnt <= '0;
            pclk    <= ~pclk;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/udma_cpi_tx.sv
// CPI transmitter / sensor emulator: streams uDMA pixels out with frame timing.
module udma_cpi_tx
    import udma_cpi_tx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CNT_WIDTH  = CPI_CNT_WIDTH  // must match the shadow record width
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  cfg_en_i,
    input  logic [7:0]            cfg_clkdiv_i,
    input  logic [CNT_WIDTH-1:0]  cfg_width_i,
    input  logic [CNT_WIDTH-1:0]  cfg_height_i,
    input  logic [CNT_WIDTH-1:0]  cfg_hblank_i,
    input  logic [CNT_WIDTH-1:0]  cfg_vblank_i,
    input  logic [DATA_WIDTH-1:0] tx_data_i,
    input  logic                  tx_valid_i,
    output logic                  tx_ready_o,
    output logic                  cpi_pclk_o,
    output logic                  cpi_hsync_o,
    output logic                  cpi_vsync_o,
    output logic [DATA_WIDTH-1:0] cpi_data_o,
    output logic                  busy_o,
    output logic                  eof_evt_o,
    output logic                  underrun_evt_o
);

    cpi_tx_state_e         state;
    cpi_tx_cfg_t           shadow;
    cpi_tx_cfg_t           cfg_in;
    logic [CNT_WIDTH-1:0]  cnt;
    logic [CNT_WIDTH-1:0]  px;
    logic [CNT_WIDTH-1:0]  line;
    logic                  fall;
    logic                  run;
    logic                  vblank_done;
    logic                  hblank_done;
    logic                  line_done;
    logic                  lines_left;
    logic                  pixel_slot;
    logic [DATA_WIDTH-1:0] slot_data;

    assign cfg_in = '{clkdiv: cfg_clkdiv_i, width: cfg_width_i, height: cfg_height_i,
                      hblank: cfg_hblank_i, vblank: cfg_vblank_i};

    assign run = (state != IDLE);

    cpi_tx_clkgen u_clkgen (
        .clk    (clk_i),
        .rst_n  (rstn_i),
        .clkdiv (shadow.clkdiv),
        .run    (run),
        .pclk   (cpi_pclk_o),
        .fall   (fall)
    );

    // Equality compares so full-scale counts never terminate early on wrap.
    assign vblank_done = (cnt == shadow.vblank);
    assign hblank_done = (cnt == shadow.hblank);
    assign line_done   = (px == shadow.width);
    assign lines_left  = (line != shadow.height);

    // A fall is a pixel slot when it presents the first or a following pixel of a line.
    always_comb begin
        pixel_slot = 1'b0;
        case (state)
            VBLANK:  pixel_slot = vblank_done;
            LINE:    pixel_slot = !line_done;
            HBLANK:  pixel_slot = hblank_done && lines_left;
            default: pixel_slot = 1'b0;
        endcase
    end

    assign tx_ready_o = fall && pixel_slot;
    assign slot_data  = tx_valid_i ? tx_data_i : '0;

    // Frame FSM: blanking/pixel counters, sync outputs, pixel register and events.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state          <= IDLE;
            shadow         <= '0;
            cnt            <= '0;
            px             <= '0;
            line           <= '0;
            cpi_hsync_o    <= 1'b0;
            cpi_vsync_o    <= 1'b0;
            cpi_data_o     <= '0;
            busy_o         <= 1'b0;
            eof_evt_o      <= 1'b0;
            underrun_evt_o <= 1'b0;
        end else begin
            eof_evt_o      <= 1'b0;
            underrun_evt_o <= 1'b0;
            // Every pixel slot presents a byte; a missing one goes out as zero without stalling.
            if (tx_ready_o) begin
                cpi_data_o     <= slot_data;
                underrun_evt_o <= !tx_valid_i;
            end
            case (state)
                IDLE: begin
                    if (cfg_en_i) begin
                        state       <= VBLANK;
                        busy_o      <= 1'b1;
                        cpi_vsync_o <= 1'b1;
                        shadow      <= cfg_in;
                        cnt         <= '0;
                        px          <= '0;
                        line        <= '0;
                    end
                end
                VBLANK: begin
                    if (fall) begin
                        if (vblank_done) begin
                            state       <= LINE;
                            cpi_vsync_o <= 1'b0;
                            cpi_hsync_o <= 1'b1;
                            cnt         <= '0;
                            px          <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                LINE: begin
                    if (fall) begin
                        if (line_done) begin
                            state       <= HBLANK;
                            cpi_hsync_o <= 1'b0;
                            cpi_data_o  <= '0;
                            cnt         <= '0;
                        end else begin
                            px <= px + 1'b1;
                        end
                    end
                end
                HBLANK: begin
                    if (fall) begin
                        if (!hblank_done) begin
                            cnt <= cnt + 1'b1;
                        end else if (lines_left) begin
                            state       <= LINE;
                            cpi_hsync_o <= 1'b1;
                            px          <= '0;
                            cnt         <= '0;
                            line        <= line + 1'b1;
                        end else begin
                            eof_evt_o <= 1'b1;
                            cnt       <= '0;
                            line      <= '0;
                            if (cfg_en_i) begin
                                state       <= VBLANK;
                                cpi_vsync_o <= 1'b1;
                                shadow      <= cfg_in;
                            end else begin
                                state  <= IDLE;
                                busy_o <= 1'b0;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_udma_cpi_tx.sv
// Directed bench for udma_cpi_tx: receiver model on pclk rising edges plus stream source.
module tb_udma_cpi_tx;

    localparam int LIMIT = 3000;
    localparam int BASE  = 8'h10;

    logic        clk = 1'b0;
    logic        rstn_i;
    logic        cfg_en_i;
    logic [7:0]  cfg_clkdiv_i;
    logic [15:0] cfg_width_i, cfg_height_i, cfg_hblank_i, cfg_vblank_i;
    logic [7:0]  tx_data_i;
    logic        tx_valid_i;
    logic        tx_ready_o, cpi_pclk_o, cpi_hsync_o, cpi_vsync_o;
    logic [7:0]  cpi_data_o;
    logic        busy_o, eof_evt_o, underrun_evt_o;

    always #5 clk = ~clk;

    udma_cpi_tx #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
        .clk_i          (clk),
        .rstn_i         (rstn_i),
        .cfg_en_i       (cfg_en_i),
        .cfg_clkdiv_i   (cfg_clkdiv_i),
        .cfg_width_i    (cfg_width_i),
        .cfg_height_i   (cfg_height_i),
        .cfg_hblank_i   (cfg_hblank_i),
        .cfg_vblank_i   (cfg_vblank_i),
        .tx_data_i      (tx_data_i),
        .tx_valid_i     (tx_valid_i),
        .tx_ready_o     (tx_ready_o),
        .cpi_pclk_o     (cpi_pclk_o),
        .cpi_hsync_o    (cpi_hsync_o),
        .cpi_vsync_o    (cpi_vsync_o),
        .cpi_data_o     (cpi_data_o),
        .busy_o         (busy_o),
        .eof_evt_o      (eof_evt_o),
        .underrun_evt_o (underrun_evt_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Receiver / monitor state
    logic       prev_pclk, prev_hsync;
    logic [7:0] prev_data;
    int         cur_len, vs_rises, hl_rises, n_under, n_eof, n_ready, viol;
    int         hi_run, lo_run, bad_hi, bad_lo, exp_half;
    int         line_lens[$];
    logic [7:0] cap[$];

    // Stream source state
    int src_idx, src_slot, src_drop;

    typedef struct {
        int cd; int w; int h; int hb; int vb; int drop;
        int exp_pix; int exp_lines; int exp_under;
    } vec_t;
    vec_t vecs[5];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    // Receiver: samples at negedge clk; pixel captured when pclk has just risen.
    initial begin
        forever begin
            @(negedge clk);
            if (tx_ready_o === 1'b1) n_ready++;
            if (underrun_evt_o === 1'b1) n_under++;
            if (eof_evt_o === 1'b1) n_eof++;
            if (((cpi_hsync_o !== prev_hsync) || (cpi_data_o !== prev_data)) &&
                !(prev_pclk === 1'b1 && cpi_pclk_o === 1'b0))
                viol++;
            if (cpi_pclk_o === 1'b1 && prev_pclk === 1'b0) begin
                if (lo_run != exp_half) bad_lo++;
                lo_run = 0;
                if (cpi_vsync_o) vs_rises++;
                if (cpi_hsync_o) begin
                    cur_len++;
                    cap.push_back(cpi_data_o);
                end else begin
                    if (cur_len > 0) begin
                        line_lens.push_back(cur_len);
                        cur_len = 0;
                    end
                    if (!cpi_vsync_o) hl_rises++;
                end
            end
            if (cpi_pclk_o === 1'b0 && prev_pclk === 1'b1) begin
                if (hi_run != exp_half) bad_hi++;
                hi_run = 0;
            end
            if (cpi_pclk_o === 1'b1) hi_run++;
            else if (busy_o === 1'b1) lo_run++;
            prev_pclk  = cpi_pclk_o;
            prev_hsync = cpi_hsync_o;
            prev_data  = cpi_data_o;
        end
    end

    // Source: byte advances after the edge that consumed it.
    initial begin
        forever begin
            @(negedge clk);
            if (tx_ready_o === 1'b1) begin
                @(posedge clk);
                #1;
                if (tx_valid_i) src_idx++;
                src_slot++;
                tx_data_i  = 8'(BASE + src_idx);
                tx_valid_i = (src_slot != src_drop);
            end
        end
    end

    task automatic clear_mon();
        prev_pclk = cpi_pclk_o; prev_hsync = cpi_hsync_o; prev_data = cpi_data_o;
        cur_len = 0; vs_rises = 0; hl_rises = 0; n_under = 0; n_eof = 0; n_ready = 0;
        viol = 0; hi_run = 0; lo_run = 0; bad_hi = 0; bad_lo = 0;
        line_lens.delete();
        cap.delete();
    endtask

    task automatic setup(input int cd, input int w, input int h, input int hb, input int vb,
                         input int drop);
        cfg_en_i = 1'b0;
        rstn_i   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        clear_mon();
        exp_half     = cd + 1;
        cfg_clkdiv_i = 8'(cd);
        cfg_width_i  = 16'(w);
        cfg_height_i = 16'(h);
        cfg_hblank_i = 16'(hb);
        cfg_vblank_i = 16'(vb);
        src_idx  = 0;
        src_slot = 0;
        src_drop = drop;
        tx_data_i  = 8'(BASE);
        tx_valid_i = (drop != 0);
        @(negedge clk);
        rstn_i = 1'b1;
    endtask

    task automatic wait_hsync(input string nm);
        int t = 0;
        while (cpi_hsync_o !== 1'b1 && t < LIMIT) begin
            @(negedge clk);
            t++;
        end
        check(nm, {31'd0, cpi_hsync_o}, 1);
    endtask

    task automatic wait_idle(input string nm);
        int t = 0;
        while (busy_o !== 1'b0 && t < LIMIT) begin
            @(negedge clk);
            t++;
        end
        repeat (2) @(negedge clk);
        check(nm, {31'd0, busy_o}, 0);
    endtask

    task automatic wait_eof(input int n, input string nm);
        int t = 0;
        while (n_eof < n && t < LIMIT) begin
            @(negedge clk);
            t++;
        end
        check(nm, n_eof, n);
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        int k;
        logic [7:0] e;
        v = vecs[i];
        setup(v.cd, v.w, v.h, v.hb, v.vb, v.drop);
        @(negedge clk);
        cfg_en_i = 1'b1;
        wait_hsync($sformatf("v%0d line start", i));
        cfg_en_i = 1'b0;  // dropped in line 0: frame must still complete
        wait_idle($sformatf("v%0d idle", i));
        check($sformatf("v%0d pclk low", i), {31'd0, cpi_pclk_o}, 0);
        check($sformatf("v%0d eof", i), n_eof, 1);
        check($sformatf("v%0d ready", i), n_ready, v.exp_pix);
        check($sformatf("v%0d underrun", i), n_under, v.exp_under);
        check($sformatf("v%0d pixels", i), cap.size(), v.exp_pix);
        check($sformatf("v%0d lines", i), line_lens.size(), v.exp_lines);
        foreach (line_lens[j])
            check($sformatf("v%0d len%0d", i, j), line_lens[j], v.w + 1);
        k = 0;
        for (int s = 0; s < v.exp_pix && s < cap.size(); s++) begin
            if (s == v.drop) e = 8'h00;
            else begin
                e = 8'(BASE + k);
                k++;
            end
            check($sformatf("v%0d byte%0d", i, s), {24'd0, cap[s]}, {24'd0, e});
        end
        check($sformatf("v%0d vsync periods", i), vs_rises, v.vb + 1);
        check($sformatf("v%0d hblank periods", i), hl_rises, (v.h + 1) * (v.hb + 1));
        check($sformatf("v%0d edge align", i), viol, 0);
        check($sformatf("v%0d pclk high", i), bad_hi, 0);
        check($sformatf("v%0d pclk low", i), bad_lo, 0);
    endtask

    initial begin
        int bad;
        //                cd w  h  hb vb drop pix lines under
        vecs[0] = '{cd:0, w:3, h:1, hb:1, vb:0, drop:-1, exp_pix:8, exp_lines:2, exp_under:0};
        vecs[1] = '{cd:0, w:3, h:1, hb:1, vb:0, drop: 2, exp_pix:8, exp_lines:2, exp_under:1};
        vecs[2] = '{cd:2, w:3, h:1, hb:1, vb:0, drop:-1, exp_pix:8, exp_lines:2, exp_under:0};
        vecs[3] = '{cd:1, w:0, h:0, hb:0, vb:2, drop:-1, exp_pix:1, exp_lines:1, exp_under:0};
        vecs[4] = '{cd:0, w:0, h:2, hb:0, vb:0, drop:-1, exp_pix:3, exp_lines:3, exp_under:0};

        rstn_i = 1'b0; cfg_en_i = 1'b0; cfg_clkdiv_i = '0; cfg_width_i = '0;
        cfg_height_i = '0; cfg_hblank_i = '0; cfg_vblank_i = '0;
        tx_data_i = '0; tx_valid_i = 1'b0; src_drop = -1; src_idx = 0; src_slot = 0;
        exp_half = 1;
        clear_mon();
        repeat (3) @(negedge clk);
        check("rst pclk",  {31'd0, cpi_pclk_o}, 0);
        check("rst hsync", {31'd0, cpi_hsync_o}, 0);
        check("rst vsync", {31'd0, cpi_vsync_o}, 0);
        check("rst data",  {24'd0, cpi_data_o}, 0);
        check("rst busy",  {31'd0, busy_o}, 0);
        check("rst ready", {31'd0, tx_ready_o}, 0);
        check("rst eof",   {31'd0, eof_evt_o}, 0);
        check("rst under", {31'd0, underrun_evt_o}, 0);

        for (int i = 0; i < 5; i++) run_vec(i);

        // Width change mid-frame applies to the next frame only.
        setup(0, 3, 1, 1, 0, -1);
        @(negedge clk);
        cfg_en_i = 1'b1;
        wait_hsync("wchg start");
        cfg_width_i = 16'd7;
        wait_eof(1, "wchg eof1");
        wait_hsync("wchg frame2");
        cfg_en_i = 1'b0;
        wait_idle("wchg idle");
        check("wchg eof2", n_eof, 2);
        check("wchg lines", line_lens.size(), 4);
        if (line_lens.size() == 4) begin
            check("wchg len0", line_lens[0], 4);
            check("wchg len1", line_lens[1], 4);
            check("wchg len2", line_lens[2], 8);
            check("wchg len3", line_lens[3], 8);
        end
        check("wchg pixels", cap.size(), 24);
        bad = 0;
        foreach (cap[j]) if (cap[j] !== 8'(BASE + j)) bad++;
        check("wchg bytes", bad, 0);

        // Reset in the middle of a line.
        setup(1, 3, 1, 1, 0, -1);
        @(negedge clk);
        cfg_en_i = 1'b1;
        wait_hsync("rmid start");
        repeat (5) @(negedge clk);
        check("rmid in line", {31'd0, cpi_hsync_o}, 1);
        rstn_i = 1'b0;
        #1;
        check("rmid pclk",  {31'd0, cpi_pclk_o}, 0);
        check("rmid hsync", {31'd0, cpi_hsync_o}, 0);
        check("rmid vsync", {31'd0, cpi_vsync_o}, 0);
        check("rmid data",  {24'd0, cpi_data_o}, 0);
        check("rmid busy",  {31'd0, busy_o}, 0);
        check("rmid ready", {31'd0, tx_ready_o}, 0);
        check("rmid under", {31'd0, underrun_evt_o}, 0);
        repeat (4) @(negedge clk);
        check("rmid no eof", n_eof, 0);
        rstn_i = 1'b1;
        @(posedge clk);
        #1;
        check("rmid restart vsync", {31'd0, cpi_vsync_o}, 1);
        check("rmid restart busy",  {31'd0, busy_o}, 1);
        check("rmid restart pclk",  {31'd0, cpi_pclk_o}, 0);
        check("rmid restart hsync", {31'd0, cpi_hsync_o}, 0);
        wait_hsync("rmid line");
        cfg_en_i = 1'b0;
        wait_idle("rmid idle");
        check("rmid eof", n_eof, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
